// File: rtl/ctr_drbg_generate.sv
// CTR_DRBG (AES-256) generate controller: streams AES_Key(V+1) blocks, then refreshes Key/V via update_proc.
// Optional additional-input support is enabled with the DRBG_ADDIN_EN macro.
module ctr_drbg_generate #(
  parameter int                 BLK_W           = 8,
  parameter int                 CTR_W           = 49,
  parameter logic [CTR_W-1:0]   RESEED_INTERVAL = CTR_W'(64'h0001_0000_0000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLK_W-1:0]   req_blocks,
  input  logic [255:0]       key_in,
  input  logic [127:0]       v_in,
  input  logic [CTR_W-1:0]   reseed_ctr_in,
  output logic [127:0]       rnd_data,
  output logic               rnd_valid,
  input  logic               rnd_ready,
  output logic               aes_start,
  output logic [255:0]       aes_key,
  output logic [127:0]       aes_block,
  input  logic [127:0]       aes_result,
  input  logic               aes_done,
  output logic               upd_start,
  output logic [383:0]       upd_provided_data,
  output logic [255:0]       upd_key_in,
  output logic [127:0]       upd_v_in,
  input  logic [255:0]       upd_key_out,
  input  logic [127:0]       upd_v_out,
  input  logic               upd_done,
  output logic [255:0]       key_out,
  output logic [127:0]       v_out,
  output logic [CTR_W-1:0]   reseed_ctr_out,
  output logic               reseed_required,
  output logic               busy,
  output logic               done
`ifdef DRBG_ADDIN_EN
  ,
  input  logic [383:0]       addin_data
`endif
);

  typedef enum logic [2:0] {
    IDLE, INC, AES_REQ, AES_WAIT, OUT, UPD_REQ, UPD_WAIT, FIN
  } state_t;

  state_t             state;
  logic [255:0]       key_r;
  logic [127:0]       v_r;
  logic [CTR_W-1:0]   ctr_r;
  logic [BLK_W-1:0]   cnt_r;
  logic               pre_upd;   // current update is the pre-generate one
  logic               pre_needed;

`ifdef DRBG_ADDIN_EN
  logic [383:0]       addin_r;
  assign pre_needed = (addin_data != '0);
`else
  assign pre_needed = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the Key/V datapath is reset as well, so no key material from an
      // aborted request can remain visible on any output.
      state             <= IDLE;
      key_r             <= '0;
      v_r               <= '0;
      ctr_r             <= '0;
      cnt_r             <= '0;
      pre_upd           <= 1'b0;
      rnd_data          <= '0;
      rnd_valid         <= 1'b0;
      aes_start         <= 1'b0;
      aes_key           <= '0;
      aes_block         <= '0;
      upd_start         <= 1'b0;
      upd_provided_data <= '0;
      upd_key_in        <= '0;
      upd_v_in          <= '0;
      key_out           <= '0;
      v_out             <= '0;
      reseed_ctr_out    <= '0;
      reseed_required   <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
`ifdef DRBG_ADDIN_EN
      addin_r           <= '0;
`endif
    end else begin
      aes_start       <= 1'b0;
      upd_start       <= 1'b0;
      done            <= 1'b0;
      reseed_required <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            key_r <= key_in;
            v_r   <= v_in;
            ctr_r <= reseed_ctr_in;
            cnt_r <= req_blocks;
            busy  <= 1'b1;
`ifdef DRBG_ADDIN_EN
            addin_r <= addin_data;
`endif
            if (reseed_ctr_in > RESEED_INTERVAL) begin
              reseed_required <= 1'b1;
              done            <= 1'b1;
              state           <= FIN;
            end else if (pre_needed) begin
              pre_upd <= 1'b1;
              state   <= UPD_REQ;
            end else if (req_blocks == '0) begin
              state <= UPD_REQ;
            end else begin
              state <= INC;
            end
          end
        end

        INC: begin
          v_r       <= v_r + 128'd1;
          aes_key   <= key_r;
          aes_block <= v_r + 128'd1;
          aes_start <= 1'b1;
          state     <= AES_REQ;
        end

        AES_REQ: state <= AES_WAIT;

        AES_WAIT: begin
          if (aes_done) begin
            rnd_data  <= aes_result;
            rnd_valid <= 1'b1;
            state     <= OUT;
          end
        end

        OUT: begin
          if (rnd_ready) begin
            rnd_valid <= 1'b0;
            cnt_r     <= cnt_r - BLK_W'(1);
            state     <= (cnt_r == BLK_W'(1)) ? UPD_REQ : INC;
          end
        end

        UPD_REQ: begin
          upd_start  <= 1'b1;
          upd_key_in <= key_r;
          upd_v_in   <= v_r;
`ifdef DRBG_ADDIN_EN
          upd_provided_data <= addin_r;
`endif
          state      <= UPD_WAIT;
        end

        UPD_WAIT: begin
          if (upd_done) begin
            if (pre_upd) begin
              pre_upd <= 1'b0;
              key_r   <= upd_key_out;
              v_r     <= upd_v_out;
              state   <= (cnt_r == '0) ? UPD_REQ : INC;
            end else begin
              key_out        <= upd_key_out;
              v_out          <= upd_v_out;
              reseed_ctr_out <= ctr_r + CTR_W'(1);
              done           <= 1'b1;
              state          <= FIN;
            end
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctr_drbg_generate.sv
// Self-checking bench for ctr_drbg_generate: transaction-level model of the generate call,
// AES (block^key[127:0]) and update_proc (~key, v+5) responders, and one per-cycle compare process.
module tb_ctr_drbg_generate;
  localparam int BLK_W = 8;
  localparam int CTR_W = 49;
  localparam logic [CTR_W-1:0] INTERVAL = CTR_W'(64'h0001_0000_0000_0000);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [BLK_W-1:0]   req_blocks;
  logic [255:0]       key_in;
  logic [127:0]       v_in;
  logic [CTR_W-1:0]   reseed_ctr_in;
  logic [127:0]       rnd_data;
  logic               rnd_valid;
  logic               rnd_ready;
  logic               aes_start;
  logic [255:0]       aes_key;
  logic [127:0]       aes_block;
  logic [127:0]       aes_result;
  logic               aes_done;
  logic               upd_start;
  logic [383:0]       upd_provided_data;
  logic [255:0]       upd_key_in;
  logic [127:0]       upd_v_in;
  logic [255:0]       upd_key_out;
  logic [127:0]       upd_v_out;
  logic               upd_done;
  logic [255:0]       key_out;
  logic [127:0]       v_out;
  logic [CTR_W-1:0]   reseed_ctr_out;
  logic               reseed_required;
  logic               busy;
  logic               done;
`ifdef DRBG_ADDIN_EN
  logic [383:0]       addin_data = '0;
`endif

  ctr_drbg_generate #(.BLK_W(BLK_W), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .req_blocks(req_blocks),
    .key_in(key_in), .v_in(v_in), .reseed_ctr_in(reseed_ctr_in),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .aes_start(aes_start), .aes_key(aes_key), .aes_block(aes_block),
    .aes_result(aes_result), .aes_done(aes_done),
    .upd_start(upd_start), .upd_provided_data(upd_provided_data),
    .upd_key_in(upd_key_in), .upd_v_in(upd_v_in),
    .upd_key_out(upd_key_out), .upd_v_out(upd_v_out), .upd_done(upd_done),
    .key_out(key_out), .v_out(v_out), .reseed_ctr_out(reseed_ctr_out),
    .reseed_required(reseed_required), .busy(busy), .done(done)
`ifdef DRBG_ADDIN_EN
    , .addin_data(addin_data)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Reference model state for the call in flight
  logic [127:0]     exp_blk_q[$];
  logic [127:0]     exp_rnd_q[$];
  logic [255:0]     exp_aes_key, exp_upd_key, exp_key_out;
  logic [127:0]     exp_upd_v, exp_v_out;
  logic [CTR_W-1:0] exp_ctr_out;
  logic             exp_rej;
  int               cur_n;

  int n_aes, n_upd, n_hs, n_valid, n_done;
  logic [127:0] rnd_log[$];

  // Responders with programmable latency
  int aes_lat = 1, upd_lat = 3;
  int aes_cnt = 0, upd_cnt = 0;
  logic [127:0] aes_pend, upd_v_pend;
  logic [255:0] upd_k_pend;

  initial begin
    aes_done = 1'b0; aes_result = '0;
    upd_done = 1'b0; upd_key_out = '0; upd_v_out = '0;
    forever begin
      @(negedge clk);
      aes_done = 1'b0;
      if (aes_cnt > 0) begin
        aes_cnt--;
        if (aes_cnt == 0) begin aes_done = 1'b1; aes_result = aes_pend; end
      end
      if (aes_start) begin aes_cnt = aes_lat; aes_pend = aes_block ^ aes_key[127:0]; end
      upd_done = 1'b0;
      if (upd_cnt > 0) begin
        upd_cnt--;
        if (upd_cnt == 0) begin upd_done = 1'b1; upd_key_out = upd_k_pend; upd_v_out = upd_v_pend; end
      end
      if (upd_start) begin upd_cnt = upd_lat; upd_k_pend = ~upd_key_in; upd_v_pend = upd_v_in + 128'd5; end
    end
  end

  // Consumer: 0 = always ready, 1 = random, 2 = stall for bp_hold valid cycles
  int ready_mode = 0;
  int bp_hold = 0;
  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: rnd_ready = 1'b1;
        1: rnd_ready = ($urandom_range(0, 3) != 0);
        default: begin
          rnd_ready = (bp_hold == 0);
          if (rnd_valid && bp_hold > 0) bp_hold--;
        end
      endcase
    end
  end

  // Per-cycle compare process
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
  logic [127:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0; prev_done = 1'b0;
      end else begin
        if (aes_start) begin
          n_aes++;
          check("aes_while_valid", rnd_valid, 1'b0);
          if (exp_blk_q.size() != 0) begin
            check("aes_block", aes_block, exp_blk_q.pop_front());
            check("aes_key", aes_key, exp_aes_key);
          end else fail_now("aes_start unexpected");
        end
        if (upd_start) begin
          n_upd++;
          check("upd_key_in", upd_key_in, exp_upd_key);
          check("upd_v_in", upd_v_in, exp_upd_v);
          check("upd_provided", upd_provided_data, 384'd0);
        end
        if (rnd_valid) begin
          n_valid++;
          if (prev_valid && !prev_ready) check("rnd_stable", rnd_data, prev_data);
          if (rnd_ready) begin
            n_hs++;
            rnd_log.push_back(rnd_data);
            if (exp_rnd_q.size() != 0) check("rnd_data", rnd_data, exp_rnd_q.pop_front());
            else fail_now("rnd handshake unexpected");
          end
        end
        if (done) begin
          n_done++;
          check("done_one_cycle", prev_done, 1'b0);
          check("done_busy", busy, 1'b1);
          check("reseed_required", reseed_required, exp_rej);
          check("key_out", key_out, exp_key_out);
          check("v_out", v_out, exp_v_out);
          check("reseed_ctr_out", reseed_ctr_out, exp_ctr_out);
        end
        prev_valid = rnd_valid; prev_ready = rnd_ready;
        prev_data = rnd_data; prev_done = done;
      end
    end
  end

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom();
    return k;
  endfunction

  function automatic logic [127:0] rand_v();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic gen_begin(input logic [255:0] key, input logic [127:0] v,
                           input logic [CTR_W-1:0] ctr, input int n);
    cur_n = n;
    exp_rej = (ctr > INTERVAL);
    exp_blk_q.delete(); exp_rnd_q.delete(); rnd_log.delete();
    n_aes = 0; n_upd = 0; n_hs = 0; n_valid = 0; n_done = 0;
    if (!exp_rej) begin
      for (int i = 1; i <= n; i++) begin
        exp_blk_q.push_back(v + 128'(i));
        exp_rnd_q.push_back((v + 128'(i)) ^ key[127:0]);
      end
      exp_aes_key = key;
      exp_upd_key = key;
      exp_upd_v   = v + 128'(n);
      exp_key_out = ~key;
      exp_v_out   = v + 128'(n) + 128'd5;
      exp_ctr_out = ctr + CTR_W'(1);
    end
    @(posedge clk); #1;
    key_in = key; v_in = v; reseed_ctr_in = ctr; req_blocks = BLK_W'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_in = rand_key(); v_in = rand_v();
    @(negedge clk);
    check("busy_on_start", busy, 1'b1);
    if (exp_rej) begin
      check("rej_done_next", done, 1'b1);
      check("rej_flag_next", reseed_required, 1'b1);
    end
  endtask

  task automatic gen_finish(input bit glitch);
    int cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = (glitch && cyc == 3);
      if (start) begin
        key_in = rand_key(); v_in = rand_v();
        reseed_ctr_in = CTR_W'($urandom()); req_blocks = BLK_W'($urandom_range(1, 5));
      end
    end
    start = 1'b0;
    if (n_done == 0) fail_now("gen_timeout no done pulse");
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("n_aes", n_aes, exp_rej ? 0 : cur_n);
    check("n_upd", n_upd, exp_rej ? 0 : 1);
    check("n_hs", n_hs, exp_rej ? 0 : cur_n);
    check("n_done", n_done, 1);
    check("rnd_q_left", exp_rnd_q.size(), 0);
    if (cur_n == 0 || exp_rej) check("n_valid", n_valid, 0);
  endtask

  task automatic run_gen(input logic [255:0] key, input logic [127:0] v,
                         input logic [CTR_W-1:0] ctr, input int n, input bit glitch);
    gen_begin(key, v, ctr, n);
    gen_finish(glitch);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [127:0] v0;
    rst = 1'b1; start = 1'b0; req_blocks = '0; key_in = '0; v_in = '0; reseed_ctr_in = '0;
    exp_key_out = '0; exp_v_out = '0; exp_ctr_out = '0; exp_rej = 1'b0;
    exp_aes_key = '0; exp_upd_key = '0; exp_upd_v = '0; cur_n = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_key_out", key_out, 256'd0);
    check("reset_rnd_valid", rnd_valid, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic: two blocks with all-ones key
    v0 = 128'h123456789ABCDEF0123456789ABCDEF0;
    run_gen({256{1'b1}}, v0, CTR_W'(41), 2, 1'b0);
    check("basic_blk0_lit", rnd_log[0], 128'hEDCBA9876543210FEDCBA9876543210E);
    check("basic_blk1_lit", rnd_log[1], 128'hEDCBA9876543210FEDCBA9876543210D);
    check("basic_key_lit", key_out, 256'd0);
    check("basic_v_lit", v_out, 128'h123456789ABCDEF0123456789ABCDEF7);
    check("basic_ctr_lit", reseed_ctr_out, CTR_W'(42));

    // Wrap: V all ones increments to zero
    run_gen(rand_key(), {128{1'b1}}, CTR_W'(7), 1, 1'b0);
    check("wrap_v_lit", v_out, 128'd5);

    // Backpressure: consumer stalls for 10 valid cycles, plus a start while busy
    ready_mode = 2; bp_hold = 10;
    run_gen(rand_key(), rand_v(), CTR_W'(3), 2, 1'b1);
    check("bp_stalled", (n_valid >= 11), 1'b1);
    ready_mode = 0;

    // Reseed limit: rejected, outputs keep the previous result
    run_gen(rand_key(), rand_v(), INTERVAL + CTR_W'(1), 3, 1'b0);
    // Boundary: exactly at the interval is still allowed
    run_gen(rand_key(), rand_v(), INTERVAL, 1, 1'b0);
    // Zero blocks: update only
    run_gen(rand_key(), rand_v(), CTR_W'(9), 0, 1'b0);

    // Reset during AES_WAIT with a slow AES core
    aes_lat = 5;
    gen_begin(rand_key(), 128'h0F0F_0000_0000_0000_0000_0000_0000_0100, CTR_W'(1), 1);
    cyc = 0;
    while (n_aes == 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (n_aes == 0) fail_now("rst_test no aes_start");
    rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_aes_block", aes_block, 128'd0);
    check("rst_aes_key", aes_key, 256'd0);
    check("rst_key_out", key_out, 256'd0);
    check("rst_v_out", v_out, 128'd0);
    exp_blk_q.delete(); exp_rnd_q.delete();
    exp_key_out = '0; exp_v_out = '0; exp_ctr_out = '0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("late_aes_busy", busy, 1'b0);
      check("late_aes_valid", rnd_valid, 1'b0);
    end
    aes_lat = 1;
    run_gen(rand_key(), rand_v(), CTR_W'(100), 2, 1'b0);

    // Randomized calls
    for (int it = 0; it < 24; it++) begin
      logic [CTR_W-1:0] ctr;
      logic [127:0] v;
      int n, sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: ctr = INTERVAL;
        1: ctr = INTERVAL + CTR_W'(1);
        2: ctr = {CTR_W{1'b1}};
        default: ctr = CTR_W'($urandom());
      endcase
      v = ($urandom_range(0, 3) == 0) ? ~128'($urandom_range(0, 3)) : rand_v();
      n = $urandom_range(0, 5);
      ready_mode = $urandom_range(0, 1);
      aes_lat = $urandom_range(1, 3);
      upd_lat = $urandom_range(1, 4);
      run_gen(rand_key(), v, ctr, n, (n > 0) && (ctr <= INTERVAL) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ctr_drbg_generate.md
Name: ctr_drbg_generate

Overview:
- CTR_DRBG (AES-256, seedlen 384) generate-process controller.
- Takes the current working state (Key, V, reseed counter) and streams req_blocks 128-bit random blocks.
- Each block is AES_Key(V+1), produced by an external AES core.
- After the last block it acts as the initiator of the update_proc start/done handshake to refresh Key/V, then returns the new state and the incremented reseed counter to the state owner.

Parameters:
- BLK_W, 8, width of req_blocks.
- CTR_W, 49, reseed counter width.
- RESEED_INTERVAL, 2**48, maximum generate calls allowed before a reseed is required.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle generate request
- req_blocks  in  BLK_W  number of 128-bit output blocks
- key_in  in  256  working-state Key
- v_in  in  128  working-state V
- reseed_ctr_in  in  CTR_W  current reseed counter
- rnd_data  out  128  random output block
- rnd_valid  out  1  rnd_data valid
- rnd_ready  in  1  consumer accepts rnd_data
- aes_start  out  1  one-cycle AES request
- aes_key  out  256  AES key
- aes_block  out  128  AES plaintext
- aes_result  in  128  AES ciphertext
- aes_done  in  1  one-cycle AES completion
- upd_start  out  1  one-cycle update_proc start
- upd_provided_data  out  384  update_proc provided_data
- upd_key_in  out  256  update_proc key_in
- upd_v_in  out  128  update_proc v_in
- upd_key_out  in  256  update_proc key_out
- upd_v_out  in  128  update_proc v_out
- upd_done  in  1  update_proc done
- key_out  out  256  new Key
- v_out  out  128  new V
- reseed_ctr_out  out  CTR_W  reseed_ctr_in+1
- reseed_required  out  1  request rejected, reseed first
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal Key/V/count registers cleared.
- Reset asserted mid-operation aborts immediately; no partial state is returned.
- start is sampled only in IDLE. start while busy is ignored.
- At start, the block latches key_in, v_in, reseed_ctr_in and req_blocks.
- If reseed_ctr_in > RESEED_INTERVAL: next cycle reseed_required=1 and done=1 (both one cycle); no AES or update traffic; key_out/v_out/reseed_ctr_out unchanged.
- If req_blocks==0: skip straight to the UPD_REQ state (the update still runs, as per 90A).
- States:
  - IDLE -> INC (V <= V+1 mod 2^128; all-ones wraps to 0).
  - INC -> AES_REQ: aes_start=1 for one cycle; aes_key=Key, aes_block=V. aes_key/aes_block are held stable until aes_done.
  - AES_REQ -> AES_WAIT until aes_done; capture aes_result.
  - AES_WAIT -> OUT: rnd_valid=1, rnd_data held stable until rnd_valid&&rnd_ready. On that handshake the block count decrements; if the count is nonzero go to INC, else go to UPD_REQ. rnd_valid drops the cycle after the handshake.
  - UPD_REQ: upd_start=1 for one cycle; upd_key_in=Key, upd_v_in=V (the last incremented V), upd_provided_data=0 (see optional feature).
  - UPD_REQ -> UPD_WAIT until upd_done; register upd_key_out/upd_v_out into key_out/v_out and set reseed_ctr_out=reseed_ctr_in+1.
  - UPD_WAIT -> FIN: done=1 for one cycle -> IDLE.
- key_out/v_out/reseed_ctr_out hold until the next completed generate.
- aes_done or upd_done arriving outside their wait states is ignored.
- aes_done may arrive in the cycle after aes_start at the earliest.
- Minimum latency per block with an AES core that responds in 1 cycle and rnd_ready held high: 4 cycles.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: DRBG_ADDIN_EN.
- When defined:
  - Adds port addin_data in 384, latched at start.
  - If addin_data is nonzero, a pre-generate update (UPD_REQ/UPD_WAIT with provided_data=addin_data) runs before the first INC, and its result replaces Key/V.
  - The final update also uses provided_data=addin_data.
  - If addin_data==0, behaviour is identical to the macro-off build.
- When undefined: no addin port; provided_data is always 0.

Test Plan:
- Bench models AES as result=block^key[127:0] with 1-cycle latency, and update_proc as key_out=~key_in, v_out=v_in+5 with 3-cycle latency.
- Basic:
  - Stimulus: key_in=256'hFF..FF, v_in=128'h123456789ABCDEF0123456789ABCDEF0, req_blocks=2, rnd_ready=1.
  - Required: rnd_data = (v_in+1)^{128{1'b1}}, then (v_in+2)^{128{1'b1}}; key_out=0; v_out=v_in+7; reseed_ctr_out=in+1; one done pulse.
- Wrap:
  - Stimulus: v_in=128'hFF..FF, req_blocks=1.
  - Required: aes_block=0; v_out=5.
- Backpressure:
  - Stimulus: rnd_ready held low for 10 cycles.
  - Required: rnd_valid and rnd_data held stable; no second aes_start until the handshake.
- Reseed limit:
  - Stimulus: reseed_ctr_in=RESEED_INTERVAL+1.
  - Required: reseed_required=1 and done=1 the next cycle; aes_start and upd_start never asserted.
- Zero blocks:
  - Stimulus: req_blocks=0.
  - Required: no rnd_valid; exactly one upd_start; done asserted.
- Reset mid-AES_WAIT:
  - Stimulus: assert rst during AES_WAIT.
  - Required: all outputs 0 immediately; a late aes_done is ignored; a fresh start then completes normally.
